// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: latches the CPU's display value (syscall 34) or selects
// one of three performance counters, then scans the selected 32-bit value
// as 8 hex digits across a common-anode seven-segment display.
module seg_display_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        led_cpu_enable,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [1:0]  disp_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [31:0] disp_value,
  output logic        led_valid
);

  // Smallest width that holds SCAN_DIV-1 (SCAN_DIV >= 2 guarantees >= 1 bit).
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SRC_LED     = 2'd0,
    SRC_CYCLES  = 2'd1,
    SRC_CONDI   = 2'd2,
    SRC_UNCONDI = 2'd3
  } src_e;

  logic [31:0]   led_latch_q,  led_latch_d;
  logic          led_valid_q,  led_valid_d;
  logic [31:0]   disp_value_q, disp_value_d;
  logic [1:0]    sel_q,        sel_d;
  logic [PW-1:0] prescaler_q,  prescaler_d;
  logic [2:0]    idx_q,        idx_d;
  logic          active_q,     active_d;
  logic [7:0]    an_q,         an_d;
  logic [7:0]    seg_q,        seg_d;
  logic          tick;
  logic [3:0]    nibble;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hexdecode(input logic [3:0] h);
    case (h)
      4'h0: hexdecode = 7'h40;
      4'h1: hexdecode = 7'h79;
      4'h2: hexdecode = 7'h24;
      4'h3: hexdecode = 7'h30;
      4'h4: hexdecode = 7'h19;
      4'h5: hexdecode = 7'h12;
      4'h6: hexdecode = 7'h02;
      4'h7: hexdecode = 7'h78;
      4'h8: hexdecode = 7'h00;
      4'h9: hexdecode = 7'h10;
      4'hA: hexdecode = 7'h08;
      4'hB: hexdecode = 7'h03;
      4'hC: hexdecode = 7'h46;
      4'hD: hexdecode = 7'h21;
      4'hE: hexdecode = 7'h06;
      default: hexdecode = 7'h0E;
    endcase
  endfunction

  assign tick   = (prescaler_q == PRE_MAX);
  assign nibble = disp_value_q[{idx_q, 2'b00} +: 4];

  // Next-state logic: LED latch, source mux, prescaler/digit index, output stage.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    led_latch_d  = led_latch_q;
    led_valid_d  = led_valid_q;
    disp_value_d = disp_value_q;
    sel_d        = disp_sel;
    prescaler_d  = prescaler_q + PW'(1);
    idx_d        = idx_q;
    active_d     = active_q;
    an_d         = 8'hFF;
    seg_d        = 8'hFF;

    if (led_cpu_enable) begin
      led_latch_d = led_data_in;
      led_valid_d = 1'b1;
    end

    case (src_e'(disp_sel))
      SRC_LED:     disp_value_d = led_latch_q;
      SRC_CYCLES:  disp_value_d = total_cycles;
      SRC_CONDI:   disp_value_d = condi_branch_num;
      default:     disp_value_d = uncondi_branch_num;
    endcase

    if (tick) begin
      prescaler_d = '0;
      idx_d       = idx_q + 3'd1;
      active_d    = 1'b1;
    end

    // The decimal point marks the rightmost digit when a counter is shown;
    // the registered select keeps dp aligned with the registered value.
    if (active_q) begin
      an_d       = ~(8'b1 << idx_q);
      seg_d[6:0] = hexdecode(nibble);
      seg_d[7]   = !((idx_q == 3'd0) && (sel_q != 2'd0));
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      led_latch_q  <= '0;
      led_valid_q  <= 1'b0;
      disp_value_q <= '0;
      sel_q        <= '0;
      prescaler_q  <= '0;
      idx_q        <= '0;
      active_q     <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
    end else begin
      led_latch_q  <= led_latch_d;
      led_valid_q  <= led_valid_d;
      disp_value_q <= disp_value_d;
      sel_q        <= sel_d;
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign disp_value = disp_value_q;
  assign led_valid  = led_valid_q;

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Downstream consumer of the single-cycle CPU's display and statistics outputs.
- Latches the syscall-34 display value, or selects one of the three performance counters.
- Time-multiplexes the selected 32-bit value as 8 hex digits onto a common-anode 8-digit seven-segment display.
- Sits between the CPU and the board pins.

Parameters:
- SCAN_DIV, default 100000: clock cycles per digit slot. Must be >= 2. The prescaler width is the minimum width that holds SCAN_DIV-1.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  system clock, same clock as the CPU.
- rst  input  1  synchronous active-high reset.
- led_cpu_enable  input  1  CPU strobe: a syscall with $v0 == 34 is executing this cycle.
- led_data_in  input  32  CPU value to display ($a0). Valid when led_cpu_enable = 1.
- total_cycles  input  32  CPU cycle counter.
- condi_branch_num  input  32  taken conditional-branch counter.
- uncondi_branch_num  input  32  unconditional jump counter.
- disp_sel  input  2  display source select: 0 = latched LED value, 1 = total_cycles, 2 = condi_branch_num, 3 = uncondi_branch_num.
- an  output  8  digit enables, active low. an[0] is the rightmost digit.
- seg  output  8  segment drive, active low, bit order {dp,g,f,e,d,c,b,a}.
- disp_value  output  32  registered, currently selected value (debug/bench visibility).
- led_valid  output  1  sticky: at least one led_cpu_enable strobe has occurred since reset.

Behaviour:
- Reset: all internal and output registers take these values on the first rising edge with rst = 1.
  - led_latch = 0, led_valid = 0, disp_value = 0.
  - prescaler = 0, idx = 0, active = 0.
  - an = 8'hFF, seg = 8'hFF (display dark).
- Reset asserted mid-scan returns every register to its reset value at that edge, regardless of prescaler or idx state.
- LED latch: on each edge with led_cpu_enable = 1, led_latch <= led_data_in and led_valid <= 1.
  - Back-to-back strobes: the last one wins, updated every cycle.
  - With led_cpu_enable = 0, led_latch holds.
- Source mux: each cycle disp_value <= the source chosen by disp_sel, using that cycle's inputs. When disp_sel = 0 the source is led_latch, so a strobe reaches disp_value 2 cycles after the strobe edge.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - tick = (prescaler == SCAN_DIV-1). On tick the prescaler wraps to 0.
  - On tick, idx <= idx+1 mod 8 (7 wraps to 0) and active <= 1.
  - The first tick occurs SCAN_DIV cycles after reset release and leaves idx = 1.
- Output stage: each cycle while active = 1:
  - an <= ~(8'b1 << idx).
  - seg[6:0] <= hexdecode(disp_value[4*idx+3 : 4*idx]).
  - seg[7] <= 0 (dp lit) only when idx == 0 and disp_sel != 0; otherwise seg[7] <= 1.
- While active = 0, an and seg hold 8'hFF.
- Exactly one an bit is low at any time once active.
- Latency:
  - an and seg lag idx by 1 cycle.
  - seg lags disp_value by 1 cycle.
  - A disp_sel change reaches seg in 2 cycles.
- hexdecode seg[6:0] (hex):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78.
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E.
- No leading-zero blanking. All 8 digits are always shown.
- Simultaneous events:
  - A strobe and a tick in the same cycle are independent. Both take effect.
  - A disp_sel change during a digit slot updates seg mid-slot, 2 cycles later. No glitch suppression is required.

Test Plan:
- Reset with SCAN_DIV = 4: hold rst for 2 cycles, then release.
  - an = FF and seg = FF for 4 cycles.
  - After the first tick, an = FD (idx 1) one cycle later.
  - Digits then rotate FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles.
- LED latch, disp_sel = 0: strobe led_cpu_enable for 1 cycle with led_data_in = 32'h1234ABCD.
  - disp_value = 1234ABCD two cycles later; led_valid = 1.
  - Over one scan period, seg low bits read idx 0 = 21 (d), 1 = 46 (C), 2 = 03 (b), 3 = 08 (A), 4 = 19, 5 = 30, 6 = 24, 7 = 79.
  - seg[7] = 1 throughout.
- Counter mode: set disp_sel = 1 with total_cycles = 32'h00000010.
  - At idx 0: seg = 0x40 with dp low (full byte 8'h40).
  - At idx 1: seg = 8'hF9.
  - All other digits: seg = 8'hC0.
- Back-to-back strobes: values 5, 6, 7 on consecutive cycles, then enable low while led_data_in changes to FFFFFFFF. disp_value settles to 00000007 and holds.
- Reset mid-scan: assert rst when idx = 5 and led_valid = 1.
  - Next edge: an = FF, seg = FF, led_valid = 0, disp_value = 0.
  - After release, the scan restarts from the first tick at idx 1.
- Selection sweep: drive condi_branch_num = 32'hFEDCBA98 and uncondi_branch_num = 32'h0F0F0F0F.
  - disp_sel = 2: idx 0 shows 8 (seg[6:0] = 00) and idx 7 shows F (0E).
  - disp_sel = 3: even idx shows F (0E) and odd idx shows 0 (40).
